// File: rtl/vc_pop_scheduler.sv
// vc_pop_scheduler: tracks claimable VC0/VC1 FIFO occupancy and issues registered pop pulses.
// Define VC_WRR_EN for weighted round-robin; when it is undefined, VC0 has strict priority.
module vc_pop_scheduler #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5,
  parameter int W_W   = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [W_W-1:0]   weight_vc0,
  input  logic [W_W-1:0]   weight_vc1,
  input  logic             push_vc0,
  input  logic             push_vc1,
  input  logic             pausa_d0,
  input  logic             pausa_d1,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             grant,
  output logic [CNT_W-1:0] occ_vc0,
  output logic [CNT_W-1:0] occ_vc1,
  output logic             sched_idle,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, SRV0 = 2'd1, SRV1 = 2'd2} state_t;

  state_t           r_state, w_state_nx;
  logic [W_W-1:0]   r_burst, w_burst_nx;
  logic [W_W-1:0]   r_w0, r_w1;
  logic             r_pause_q;
  logic             w_elig0, w_elig1;
  logic             w_pop0_nx, w_pop1_nx;
  logic             w_full_push0, w_full_push1;
  logic [CNT_W-1:0] w_occ0_nx, w_occ1_nx;
  logic             w_idle_nx;

  assign w_elig0 = (occ_vc0 != '0);
  assign w_elig1 = (occ_vc1 != '0);

  always_comb begin : arb_comb
    w_state_nx = r_state;
    w_burst_nx = r_burst;
    w_pop0_nx  = 1'b0;
    w_pop1_nx  = 1'b0;
    if (init) begin
      w_state_nx = IDLE;
      w_burst_nx = '0;
    end else if (!r_pause_q) begin
`ifdef VC_WRR_EN
      unique case (r_state)
        IDLE: begin
          if (w_elig0) begin
            w_state_nx = SRV0; w_pop0_nx = 1'b1; w_burst_nx = W_W'(1);
          end else if (w_elig1) begin
            w_state_nx = SRV1; w_pop1_nx = 1'b1; w_burst_nx = W_W'(1);
          end
        end
        SRV0: begin
          if (w_elig0 && (r_burst < r_w0)) begin
            w_pop0_nx = 1'b1; w_burst_nx = r_burst + W_W'(1);
          end else if (w_elig1) begin
            w_state_nx = SRV1; w_pop1_nx = 1'b1; w_burst_nx = W_W'(1);
          end else if (w_elig0) begin
            w_pop0_nx = 1'b1; w_burst_nx = W_W'(1);
          end else begin
            w_state_nx = IDLE;
          end
        end
        SRV1: begin
          if (w_elig1 && (r_burst < r_w1)) begin
            w_pop1_nx = 1'b1; w_burst_nx = r_burst + W_W'(1);
          end else if (w_elig0) begin
            w_state_nx = SRV0; w_pop0_nx = 1'b1; w_burst_nx = W_W'(1);
          end else if (w_elig1) begin
            w_pop1_nx = 1'b1; w_burst_nx = W_W'(1);
          end else begin
            w_state_nx = IDLE;
          end
        end
        default: w_state_nx = IDLE;
      endcase
`else
      if (w_elig0) begin
        w_state_nx = SRV0; w_pop0_nx = 1'b1;
      end else if (w_elig1) begin
        w_state_nx = SRV1; w_pop1_nx = 1'b1;
      end else begin
        w_state_nx = IDLE;
      end
`endif
    end
  end

`ifndef VC_WRR_EN
  // Weights are still latched in strict-priority builds but never consulted.
  logic w_unused_wts;
  assign w_unused_wts = ^{r_w0, r_w1};
`endif

  // A push into a full VC is dropped unless the same edge pops that VC.
  always_comb begin : occ_comb
    w_full_push0 = push_vc0 && (occ_vc0 == CNT_W'(DEPTH)) && !w_pop0_nx;
    w_full_push1 = push_vc1 && (occ_vc1 == CNT_W'(DEPTH)) && !w_pop1_nx;
    w_occ0_nx = occ_vc0;
    w_occ1_nx = occ_vc1;
    if (push_vc0 && !w_pop0_nx && !w_full_push0) w_occ0_nx = occ_vc0 + CNT_W'(1);
    else if (!push_vc0 && w_pop0_nx)             w_occ0_nx = occ_vc0 - CNT_W'(1);
    if (push_vc1 && !w_pop1_nx && !w_full_push1) w_occ1_nx = occ_vc1 + CNT_W'(1);
    else if (!push_vc1 && w_pop1_nx)             w_occ1_nx = occ_vc1 - CNT_W'(1);
    w_idle_nx = (w_occ0_nx == '0) && (w_occ1_nx == '0) && (w_state_nx == IDLE) && !init;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= IDLE;
      r_burst    <= '0;
      r_w0       <= W_W'(1);
      r_w1       <= W_W'(1);
      r_pause_q  <= 1'b0;
      pop_vc0    <= 1'b0;
      pop_vc1    <= 1'b0;
      grant      <= 1'b0;
      occ_vc0    <= '0;
      occ_vc1    <= '0;
      sched_idle <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (init) begin
        r_w0 <= (weight_vc0 == '0) ? W_W'(1) : weight_vc0;
        r_w1 <= (weight_vc1 == '0) ? W_W'(1) : weight_vc1;
      end
      r_state    <= w_state_nx;
      r_burst    <= w_burst_nx;
      r_pause_q  <= pausa_d0 | pausa_d1;
      pop_vc0    <= w_pop0_nx;
      pop_vc1    <= w_pop1_nx;
      if (w_pop0_nx)      grant <= 1'b0;
      else if (w_pop1_nx) grant <= 1'b1;
      occ_vc0    <= w_occ0_nx;
      occ_vc1    <= w_occ1_nx;
      sched_idle <= w_idle_nx;
      overflow   <= overflow | w_full_push0 | w_full_push1;
    end
  end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Bench for vc_pop_scheduler: reference model checked every cycle plus directed pop-order checks.
// Expected orders follow VC_WRR_EN when defined, strict VC0 priority otherwise.
module tb_vc_pop_scheduler;

  logic       clk = 1'b0;
  logic       reset_L, init, push_vc0, push_vc1, pausa_d0, pausa_d1;
  logic [3:0] weight_vc0, weight_vc1;
  logic       pop_vc0, pop_vc1, grant, sched_idle, overflow;
  logic [4:0] occ_vc0, occ_vc1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int q_pop[$];
  int q_cyc[$];

  vc_pop_scheduler #(.DEPTH(16), .CNT_W(5), .W_W(4)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
    .push_vc0(push_vc0), .push_vc1(push_vc1),
    .pausa_d0(pausa_d0), .pausa_d1(pausa_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .grant(grant),
    .occ_vc0(occ_vc0), .occ_vc1(occ_vc1),
    .sched_idle(sched_idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: cur is the VC being served (-1 = none), run counts pops in its current turn.
  typedef struct packed {
    int occ0; int occ1; int cur; int run; int w0; int w1;
    bit pop0; bit pop1; bit grant; bit ovf; bit idle; bit pq;
  } model_t;

  model_t m;

  function automatic model_t mstep(model_t s, bit in_init, logic [3:0] wv0, logic [3:0] wv1,
                                   bit p0, bit p1, bit pa0, bit pa1);
    model_t n;
    int pick;
    int occ[2];
    int w[2];
    bit psh[2];
    n = s;
    pick = -1;
    occ[0] = s.occ0; occ[1] = s.occ1;
    w[0] = s.w0; w[1] = s.w1;
    psh[0] = p0; psh[1] = p1;
    n.pop0 = 1'b0;
    n.pop1 = 1'b0;
    if (in_init) begin
      n.w0 = (wv0 == 4'd0) ? 1 : int'(wv0);
      n.w1 = (wv1 == 4'd0) ? 1 : int'(wv1);
      n.cur = -1;
      n.run = 0;
    end else if (!s.pq) begin
`ifdef VC_WRR_EN
      if (s.cur < 0) begin
        if (occ[0] > 0) pick = 0;
        else if (occ[1] > 0) pick = 1;
        n.run = 1;
      end else if (occ[s.cur] > 0 && s.run < w[s.cur]) begin
        pick = s.cur; n.run = s.run + 1;
      end else if (occ[1 - s.cur] > 0) begin
        pick = 1 - s.cur; n.run = 1;
      end else if (occ[s.cur] > 0) begin
        pick = s.cur; n.run = 1;
      end
`else
      if (occ[0] > 0) pick = 0;
      else if (occ[1] > 0) pick = 1;
`endif
      n.cur = pick;
    end
    if (pick == 0) begin n.pop0 = 1'b1; n.grant = 1'b0; end
    if (pick == 1) begin n.pop1 = 1'b1; n.grant = 1'b1; end
    for (int v = 0; v < 2; v++) begin
      if (psh[v]) begin
        if (occ[v] == 16 && pick != v) n.ovf = 1'b1;
        else if (pick != v) occ[v] = occ[v] + 1;
      end else if (pick == v) begin
        occ[v] = occ[v] - 1;
      end
    end
    n.occ0 = occ[0];
    n.occ1 = occ[1];
    n.idle = (occ[0] == 0) && (occ[1] == 0) && (n.cur < 0) && !in_init;
    n.pq = pa0 | pa1;
    return n;
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m <= '{occ0: 0, occ1: 0, cur: -1, run: 0, w0: 1, w1: 1,
             pop0: 1'b0, pop1: 1'b0, grant: 1'b0, ovf: 1'b0, idle: 1'b1, pq: 1'b0};
    end else begin
      m <= mstep(m, init, weight_vc0, weight_vc1, push_vc0, push_vc1, pausa_d0, pausa_d1);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model pop_vc0",    int'(pop_vc0),    int'(m.pop0));
    cmp("model pop_vc1",    int'(pop_vc1),    int'(m.pop1));
    cmp("model grant",      int'(grant),      int'(m.grant));
    cmp("model occ_vc0",    int'(occ_vc0),    m.occ0);
    cmp("model occ_vc1",    int'(occ_vc1),    m.occ1);
    cmp("model sched_idle", int'(sched_idle), int'(m.idle));
    cmp("model overflow",   int'(overflow),   int'(m.ovf));
    if (pop_vc0) begin q_pop.push_back(0); q_cyc.push_back(cyc); end
    else if (pop_vc1) begin q_pop.push_back(1); q_cyc.push_back(cyc); end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input bit a, input bit b);
    push_vc0 = a;
    push_vc1 = b;
    step();
    push_vc0 = 1'b0;
    push_vc1 = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int c = 0; c < budget && q_pop.size() < n; c++) step();
    cmp("pop count within budget", (q_pop.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic clear_log();
    q_pop.delete();
    q_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, " pop_vc0"},    int'(pop_vc0),    0);
    cmp({tag, " pop_vc1"},    int'(pop_vc1),    0);
    cmp({tag, " grant"},      int'(grant),      0);
    cmp({tag, " occ_vc0"},    int'(occ_vc0),    0);
    cmp({tag, " occ_vc1"},    int'(occ_vc1),    0);
    cmp({tag, " overflow"},   int'(overflow),   0);
    cmp({tag, " sched_idle"}, int'(sched_idle), 1);
  endtask

  int exp6[6];
  int exp8[8];

  initial begin
    reset_L = 1'b0; init = 1'b0; weight_vc0 = 4'd0; weight_vc1 = 4'd0;
    push_vc0 = 1'b0; push_vc1 = 1'b0; pausa_d0 = 1'b0; pausa_d1 = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    reset_L = 1'b1;
    step();

    // Weighted order; weight_vc1=0 must behave as 1
    init = 1'b1; weight_vc0 = 4'd2; weight_vc1 = 4'd0;
    step();
    init = 1'b0;
    pausa_d0 = 1'b1;
    step();
    repeat (3) push(1'b1, 1'b1);
    cmp("order occ_vc0 loaded", int'(occ_vc0), 3);
    cmp("order occ_vc1 loaded", int'(occ_vc1), 3);
    clear_log();
    pausa_d0 = 1'b0;
    wait_pops(6, 40);
`ifdef VC_WRR_EN
    exp6 = '{0, 0, 1, 0, 1, 1};
`else
    exp6 = '{0, 0, 0, 1, 1, 1};
`endif
    for (int i = 0; i < 6 && i < q_pop.size(); i++) cmp("order pop vc", q_pop[i], exp6[i]);
    for (int i = 1; i < 6 && i < q_cyc.size(); i++) cmp("order consecutive", q_cyc[i] - q_cyc[i-1], 1);
    step(); step();
    cmp("order idle after drain", int'(sched_idle), 1);
    cmp("order total pops", q_pop.size(), 6);

    // Single entry into vc1
    clear_log();
    push(1'b0, 1'b1);
    cmp("single occ_vc1 after push", int'(occ_vc1), 1);
    cmp("single no pop yet", int'(pop_vc1), 0);
    step();
    cmp("single pop_vc1", int'(pop_vc1), 1);
    cmp("single occ_vc1 after pop", int'(occ_vc1), 0);
    cmp("single grant", int'(grant), 1);
    step();
    cmp("single pop deasserted", int'(pop_vc1), 0);
    cmp("single pop count", q_pop.size(), 1);

    // Back-pressure on D1 mid-burst
    pausa_d0 = 1'b1;
    step();
    repeat (8) push(1'b1, 1'b0);
    clear_log();
    pausa_d0 = 1'b0;
    wait_pops(3, 20);
    pausa_d1 = 1'b1;
    step();
    cmp("bp one more pop", q_pop.size(), 4);
    repeat (4) step();
    cmp("bp no pops while paused", q_pop.size(), 4);
    cmp("bp occ_vc0 paused", int'(occ_vc0), 4);
    pausa_d1 = 1'b0;
    wait_pops(8, 30);
    repeat (3) step();
    cmp("bp total pops", q_pop.size(), 8);
    cmp("bp occ_vc0 drained", int'(occ_vc0), 0);

    // Init during an active burst
    pausa_d0 = 1'b1;
    step();
    repeat (6) push(1'b1, 1'b0);
    clear_log();
    pausa_d0 = 1'b0;
    wait_pops(2, 20);
    init = 1'b1; weight_vc0 = 4'd2; weight_vc1 = 4'd0;
    step();
    cmp("init stops pops", q_pop.size(), 2);
    cmp("init pop_vc0 low", int'(pop_vc0), 0);
    cmp("init occ held", int'(occ_vc0), 4);
    step();
    cmp("init occ still held", int'(occ_vc0), 4);
    cmp("init idle low", int'(sched_idle), 0);
    init = 1'b0;
    wait_pops(6, 30);
    repeat (3) step();
    cmp("init total pops", q_pop.size(), 6);
    cmp("init occ drained", int'(occ_vc0), 0);

    // Four entries into each VC
    pausa_d0 = 1'b1;
    step();
    repeat (4) push(1'b1, 1'b1);
    clear_log();
    pausa_d0 = 1'b0;
    wait_pops(8, 40);
`ifdef VC_WRR_EN
    exp8 = '{0, 0, 1, 0, 0, 1, 1, 1};
`else
    exp8 = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 8 && i < q_pop.size(); i++) cmp("four pop vc", q_pop[i], exp8[i]);
    repeat (3) step();
    cmp("four idle", int'(sched_idle), 1);

    // Overflow, then asynchronous reset mid-cycle
    pausa_d0 = 1'b1;
    step();
    repeat (16) push(1'b1, 1'b0);
    cmp("ovf occ full", int'(occ_vc0), 16);
    cmp("ovf not yet", int'(overflow), 0);
    push(1'b1, 1'b0);
    cmp("ovf set", int'(overflow), 1);
    cmp("ovf occ saturated", int'(occ_vc0), 16);
    repeat (3) step();
    cmp("ovf sticky", int'(overflow), 1);
    #2;
    reset_L = 1'b0;
    #1;
    check_reset_outputs("async reset");
    step();
    reset_L = 1'b1;
    pausa_d0 = 1'b0;
    step(); step();
    cmp("post reset overflow", int'(overflow), 0);
    cmp("post reset occ_vc0", int'(occ_vc0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_pop_scheduler.md
# vc_pop_scheduler

Pop scheduler for the two virtual-channel FIFOs (VC0, VC1) of the PCIE transaction layer. It sits between the VC FIFOs and the VC mux. It tracks the claimable occupancy of each VC FIFO from observed pushes and its own pops. It issues registered single-cycle pop pulses under weighted round-robin arbitration, and stalls on back-pressure from the destination FIFOs D0/D1.

## Interface
- DEPTH, 16, entries per VC FIFO
- CNT_W, 5, occupancy counter width (holds 0..DEPTH)
- W_W, 4, weight register width
- clk  in  1  clock, rising edge
- reset_L  in  1  reset, asynchronous, active-low
- init  in  1  configuration window; weights load while high
- weight_vc0  in  W_W  burst weight for VC0, sampled while init=1
- weight_vc1  in  W_W  burst weight for VC1, sampled while init=1
- push_vc0  in  1  push strobe into VC0 FIFO
- push_vc1  in  1  push strobe into VC1 FIFO
- pausa_d0  in  1  D0 FIFO pause (almost full)
- pausa_d1  in  1  D1 FIFO pause
- pop_vc0  out  1  registered pop pulse to VC0 FIFO
- pop_vc1  out  1  registered pop pulse to VC1 FIFO
- grant  out  1  VC of the most recent pop (0/1)
- occ_vc0  out  CNT_W  unclaimed entries in VC0
- occ_vc1  out  CNT_W  unclaimed entries in VC1
- sched_idle  out  1  registered; both occupancies 0, state IDLE, init low
- overflow  out  1  sticky; a push arrived into a full VC

## Operation
- Registers: state {IDLE, SRV0, SRV1}, burst counter (W_W bits), w0/w1, occ_vc0/occ_vc1, pause_q, all outputs.
- pause_q <= pausa_d0 | pausa_d1. Decisions use pause_q only.
- Occupancy: occ_next = occ + push − pop_next, where pop_next is the pop being registered at that edge. A simultaneous push and pop leaves occ unchanged.
- Eligibility: VCx is eligible when occ_vcx > 0.
- Push while occ = DEPTH and no pop_next on that VC: overflow <= 1, occ saturates at DEPTH. overflow clears only on reset.
- When init=1:
  - w0 <= weight_vc0 and w1 <= weight_vc1; a value of 0 is stored as 1.
  - State goes to IDLE, burst goes to 0, no pops are issued.
  - Occupancy tracking continues.
- When pause_q=1 and init=0: no pop is issued; state, burst and grant hold.
- Otherwise, at each edge:
  - IDLE: if VC0 eligible → SRV0, pop_vc0, burst=1. Else if VC1 eligible → SRV1, pop_vc1, burst=1. Else stay in IDLE.
  - SRV0: if VC0 eligible and burst < w0 → pop_vc0, burst+1. Else if VC1 eligible → SRV1, pop_vc1, burst=1. Else if VC0 eligible → pop_vc0, burst=1. Else → IDLE.
  - SRV1: symmetric, with w1 and a preference to switch to VC0.
- pop_vc0 and pop_vc1 are never high in the same cycle. grant <= 0 or 1 whenever a pop is registered.

## Timing
- Reset values:
  - pop_vc0 = pop_vc1 = 0, grant = 0, occ_vc0 = occ_vc1 = 0, overflow = 0, sched_idle = 1.
  - state IDLE, burst 0, w0 = w1 = 1, pause_q = 0.
- Reset mid-operation clears all registers immediately, with no wait for clk.
- Push-to-pop latency: a push at edge N (FIFO empty, idle, no pause) sets occ at edge N, and pop is high after edge N+1.
- Sustained throughput: one pop per cycle.
- Pause latency: pausa rising before edge N sets pause_q at N; the last pop is the one registered at edge N. Release is symmetric: pops resume from edge N+1 after pausa falls before edge N.
- sched_idle is updated at each edge from the next-state values.

## Configuration
- VC_WRR_EN defined: weighted round-robin as described above.
- VC_WRR_EN undefined: strict priority. VC1 is popped only when occ_vc0 = 0. Weights are still latched but ignored, and burst is unused.

## Test plan
- Weighted order: init with W0=2, W1=1; hold pausa_d0=1 while pushing 3 entries into each VC; release. Pops must run vc0, vc0, vc1, vc0, vc1, vc1 on consecutive cycles, then sched_idle=1.
- Single entry: a lone push into vc1 produces one pop_vc1 pulse two edges later; occ_vc1 goes 1→0; grant=1.
- Back-pressure: VC0 holds 8 entries; raise pausa_d1 mid-burst. Exactly one further pop occurs, then none while paused. Release and the remaining pops complete; total pops = 8.
- Overflow: with pause held, push 17 times into vc0. overflow=1 after the 17th, occ_vc0 stays 16, and overflow persists until reset_L drops mid-cycle, which clears all outputs asynchronously.
- Init: weight_vc1=0 loads as 1. Asserting init during an active burst stops pops at the next edge without changing occupancy.
- With VC_WRR_EN undefined: push 4 into each VC. All 4 vc0 pops occur before any vc1 pop.
